// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory request/response FSM, lane steering and the MEM/WB register.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module mem_stage #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [2:0]  funct3,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  memtoreg_in,
    input  logic [6:0]  opcode_in,
    input  logic [4:0]  rd_in,
    input  logic        regwrite_in,
    input  logic [31:0] return_addr_in,
    input  logic [31:0] imm_in,
    input  logic [31:0] pc_offset_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] mem_out,
    output logic [31:0] alu_out,
    output logic [31:0] return_addr,
    output logic [31:0] imm_out,
    output logic [31:0] pc_signed_offset,
    output logic [1:0]  memtoreg,
    output logic [6:0]  opcode_out_d,
    output logic [4:0]  rd_out,
    output logic        regwrite_out,
    output logic        wb_valid,
    output logic        bus_err,
    output logic        misalign
);

    // state | meaning
    // IDLE  | no access outstanding; a valid mem op requests combinationally
    // WAIT  | access issued without ack; counting towards TIMEOUT_CYC
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          mem_op;
    logic          mis;
    logic          timeout;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_data;

    assign mem_op = in_valid & (mem_read | mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis = mem_op & (((funct3[1:0] == 2'b01) & alu_result[0]) |
                           (funct3[1] & (alu_result[1:0] != 2'b00)));
`else
    assign mis = 1'b0;
`endif

    assign timeout = (state == WAIT) && (cnt == CW'(TIMEOUT_CYC));

    // The IDLE cycle that issued the request counts as the first waited cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt == WAIT) ? cnt + CW'(1) : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (dmem_req && !dmem_ack) state_nxt = WAIT;
            WAIT: if (timeout || dmem_ack)   state_nxt = IDLE;
        endcase
    end

    // Request is gated by rst so nothing is issued while the stage is being reset.
    always_comb begin
        dmem_req = 1'b0;
        case (state)
            IDLE: dmem_req = mem_op & ~mis & ~rst;
            WAIT: dmem_req = ~timeout & ~rst;
        endcase
        stall = dmem_req & ~dmem_ack;
    end

    assign dmem_addr = {alu_result[31:2], 2'b00};
    assign dmem_we   = mem_write;

    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                dmem_be    = 4'b0001 << alu_result[1:0];
                dmem_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                dmem_be    = 4'b0011 << {alu_result[1], 1'b0};
                dmem_wdata = {2{store_data[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = store_data;
            end
        endcase
    end

    always_comb begin
        case (alu_result[1:0])
            2'b00:   byte_sel = dmem_rdata[7:0];
            2'b01:   byte_sel = dmem_rdata[15:8];
            2'b10:   byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = alu_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'b0, byte_sel};
            3'b101:  load_data = {16'b0, half_sel};
            default: load_data = dmem_rdata;
        endcase
    end

    // A stalled slot leaves a bubble; completion, timeout and trap all retire it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid         <= 1'b0;
            regwrite_out     <= 1'b0;
            bus_err          <= 1'b0;
            misalign         <= 1'b0;
            mem_out          <= '0;
            alu_out          <= '0;
            return_addr      <= '0;
            imm_out          <= '0;
            pc_signed_offset <= '0;
            memtoreg         <= '0;
            opcode_out_d     <= '0;
            rd_out           <= '0;
        end else begin
            wb_valid         <= in_valid & ~stall;
            regwrite_out     <= in_valid & ~stall & regwrite_in & ~timeout & ~mis;
            bus_err          <= timeout;
            misalign         <= mis;
            mem_out          <= load_data;
            alu_out          <= alu_result;
            return_addr      <= return_addr_in;
            imm_out          <= imm_in;
            pc_signed_offset <= pc_offset_in;
            memtoreg         <= memtoreg_in;
            opcode_out_d     <= opcode_in;
            rd_out           <= rd_in;
        end
    end

endmodule
